// File: rtl/mbo_uart_tx.sv
// mbo_uart_tx: UART transmitter (8N1, LSB first) fed by a small byte FIFO.
// Define MBO_UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module mbo_uart_tx #(
    parameter int CLKS_PER_BIT = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       i_Clock,
    input  logic       rst,
    input  logic       i_Tx_DV,
    input  logic [7:0] i_Tx_Byte,
    output logic       o_Tx_Ready,
    output logic       o_Tx_Serial,
    output logic       o_Tx_Active,
    output logic       o_Tx_Done,
    output logic       o_Tx_Ovf
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
    localparam logic [15:0]      LAST_CLK   = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_STOP    = 3'd3,
        S_CLEANUP = 3'd4,
        S_PARITY  = 3'd5
    } state_t;

    state_t           state_reg;
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [7:0]       shift_reg;
    logic [2:0]       bit_idx_reg;
    logic [15:0]      clk_cnt_reg;
    logic             wr_en;
    logic             pop;
    logic             bit_end;

    // Ready comes from the registered count, so a write into a full FIFO is
    // rejected even if the FSM pops in the same cycle.
    assign o_Tx_Ready = (count_reg != FULL_COUNT);
    assign wr_en      = i_Tx_DV && o_Tx_Ready;
    assign pop        = (state_reg == S_IDLE) && (count_reg != '0);
    assign bit_end    = (clk_cnt_reg == LAST_CLK);

    always_ff @(posedge i_Clock) begin
        if (wr_en) begin
            fifo_mem[wr_ptr_reg] <= i_Tx_Byte;
        end
    end

    always_ff @(posedge i_Clock or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            o_Tx_Ovf   <= 1'b0;
        end else begin
            o_Tx_Ovf <= i_Tx_DV && !o_Tx_Ready;
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            unique case ({wr_en, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // o_Tx_Serial is driven straight from a flop so it can be packed into the IOB.
    always_ff @(posedge i_Clock or posedge rst) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            o_Tx_Serial <= 1'b1;
            o_Tx_Active <= 1'b0;
            o_Tx_Done   <= 1'b0;
            shift_reg   <= '0;
            bit_idx_reg <= '0;
            clk_cnt_reg <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    o_Tx_Serial <= 1'b1;
                    o_Tx_Active <= 1'b0;
                    o_Tx_Done   <= 1'b0;
                    if (pop) begin
                        shift_reg   <= fifo_mem[rd_ptr_reg];
                        o_Tx_Serial <= 1'b0;
                        o_Tx_Active <= 1'b1;
                        clk_cnt_reg <= '0;
                        state_reg   <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        clk_cnt_reg <= '0;
                        o_Tx_Serial <= shift_reg[0];
                        bit_idx_reg <= '0;
                        state_reg   <= S_DATA;
                    end else begin
                        clk_cnt_reg <= clk_cnt_reg + 16'd1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        clk_cnt_reg <= '0;
                        if (bit_idx_reg == 3'd7) begin
`ifdef MBO_UART_TX_PARITY_EN
                            o_Tx_Serial <= ^shift_reg;
                            state_reg   <= S_PARITY;
`else
                            o_Tx_Serial <= 1'b1;
                            state_reg   <= S_STOP;
`endif
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 3'd1;
                            o_Tx_Serial <= shift_reg[bit_idx_reg + 3'd1];
                        end
                    end else begin
                        clk_cnt_reg <= clk_cnt_reg + 16'd1;
                    end
                end
`ifdef MBO_UART_TX_PARITY_EN
                S_PARITY: begin
                    if (bit_end) begin
                        clk_cnt_reg <= '0;
                        o_Tx_Serial <= 1'b1;
                        state_reg   <= S_STOP;
                    end else begin
                        clk_cnt_reg <= clk_cnt_reg + 16'd1;
                    end
                end
`endif
                S_STOP: begin
                    if (bit_end) begin
                        clk_cnt_reg <= '0;
                        o_Tx_Active <= 1'b0;
                        o_Tx_Done   <= 1'b1;
                        state_reg   <= S_CLEANUP;
                    end else begin
                        clk_cnt_reg <= clk_cnt_reg + 16'd1;
                    end
                end
                S_CLEANUP: begin
                    o_Tx_Done <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: begin
                    o_Tx_Serial <= 1'b1;
                    o_Tx_Active <= 1'b0;
                    o_Tx_Done   <= 1'b0;
                    clk_cnt_reg <= '0;
                    state_reg   <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mbo_uart_tx.sv
// Bench for mbo_uart_tx: two instances (4 and 1 clocks per bit) checked against
// an expected line/active/done waveform built from the frame format.
module tb_mbo_uart_tx;
    localparam int CPB_A = 4;
    localparam int CPB_B = 1;
    localparam int DEPTH = 4;
`ifdef MBO_UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       dv_a, dv_b;
    logic [7:0] byte_a, byte_b;
    logic       ready_a, serial_a, active_a, done_a, ovf_a;
    logic       ready_b, serial_b, active_b, done_b, ovf_b;

    always #5 clk = ~clk;

    mbo_uart_tx #(.CLKS_PER_BIT(CPB_A), .FIFO_DEPTH(DEPTH)) dut_a (
        .i_Clock(clk), .rst(rst), .i_Tx_DV(dv_a), .i_Tx_Byte(byte_a),
        .o_Tx_Ready(ready_a), .o_Tx_Serial(serial_a), .o_Tx_Active(active_a),
        .o_Tx_Done(done_a), .o_Tx_Ovf(ovf_a)
    );

    mbo_uart_tx #(.CLKS_PER_BIT(CPB_B), .FIFO_DEPTH(DEPTH)) dut_b (
        .i_Clock(clk), .rst(rst), .i_Tx_DV(dv_b), .i_Tx_Byte(byte_b),
        .o_Tx_Ready(ready_b), .o_Tx_Serial(serial_b), .o_Tx_Active(active_b),
        .o_Tx_Done(done_b), .o_Tx_Ovf(ovf_b)
    );

    int           checks = 0;
    int           failures = 0;
    logic [511:0] obs_line, obs_act, obs_done;
    logic [511:0] exp_line, exp_act, exp_done;
    int           sidx;
    int           exp_len;
    logic [7:0]   model_q[$];

    // Expected waveform; sample 0 is the cycle right after the first write edge.
    function automatic void build_model(input int cpb);
        int          pos;
        logic [10:0] fr;
        exp_line = '1;
        exp_act  = '0;
        exp_done = '0;
        pos = 1;
        foreach (model_q[j]) begin
`ifdef MBO_UART_TX_PARITY_EN
            fr = {1'b1, ^model_q[j], model_q[j], 1'b0};
`else
            fr = {2'b11, model_q[j], 1'b0};
`endif
            for (int f = 0; f < FRAME_BITS; f++) begin
                for (int c = 0; c < cpb; c++) begin
                    exp_line[pos] = fr[f];
                    exp_act[pos]  = 1'b1;
                    pos++;
                end
            end
            exp_done[pos] = 1'b1;
            pos += 2;
        end
        exp_len = pos + 3;
    endfunction

    task automatic record(input int sel);
        if (sel == 0) begin
            obs_line[sidx] = serial_a;
            obs_act[sidx]  = active_a;
            obs_done[sidx] = done_a;
        end else begin
            obs_line[sidx] = serial_b;
            obs_act[sidx]  = active_b;
            obs_done[sidx] = done_b;
        end
        sidx++;
    endtask

    task automatic sample_n(input int sel, input int n);
        repeat (n) begin
            @(negedge clk);
            record(sel);
        end
    endtask

    task automatic drive(input int sel, input logic dv, input logic [7:0] b);
        if (sel == 0) begin
            dv_a = dv;
            byte_a = b;
        end else begin
            dv_b = dv;
            byte_b = b;
        end
    endtask

    task automatic clear_obs();
        obs_line = '1;
        obs_act  = '0;
        obs_done = '0;
        sidx = 0;
    endtask

    // Writes model_q on consecutive cycles and captures exp_len samples.
    task automatic send_burst(input int sel);
        int n = model_q.size();
        clear_obs();
        @(negedge clk);
        drive(sel, 1'b1, model_q[0]);
        for (int i = 1; i < n; i++) begin
            @(negedge clk);
            record(sel);
            drive(sel, 1'b1, model_q[i]);
        end
        @(negedge clk);
        record(sel);
        drive(sel, 1'b0, 8'($urandom));
        sample_n(sel, exp_len - n);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);
        repeat (3) @(negedge clk);
        checks++;
        if (serial_a !== 1'b1 || ready_a !== 1'b1) begin
            failures++;
            $display("FAIL reset_held serial=%b ready=%b exp 1 1", serial_a, ready_a);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({serial_a, active_a, done_a, ovf_a, ready_a} !== 5'b10001) begin
            failures++;
            $display("FAIL reset_a got=%b exp=10001", {serial_a, active_a, done_a, ovf_a, ready_a});
        end
        checks++;
        if ({serial_b, active_b, done_b, ovf_b, ready_b} !== 5'b10001) begin
            failures++;
            $display("FAIL reset_b got=%b exp=10001", {serial_b, active_b, done_b, ovf_b, ready_b});
        end
        $display("reset: a=%b b=%b", {serial_a, active_a, done_a, ovf_a, ready_a},
                 {serial_b, active_b, done_b, ovf_b, ready_b});
    endtask

    task automatic test_single_frame();
        logic [7:0] b;
        for (int it = 0; it < 3; it++) begin
            b = (it == 0) ? 8'hA5 : 8'($urandom);
            model_q = {b};
            build_model(CPB_A);
            send_burst(0);
            checks++;
            if (obs_line !== exp_line) begin
                failures++;
                $display("FAIL single_line byte=%h got=%h exp=%h", b, obs_line[63:0], exp_line[63:0]);
            end
            checks++;
            if (obs_done !== exp_done) begin
                failures++;
                $display("FAIL single_done byte=%h got=%h exp=%h", b, obs_done[63:0], exp_done[63:0]);
            end
            checks++;
            if ($countones(obs_act) != FRAME_BITS * CPB_A || obs_act !== exp_act) begin
                failures++;
                $display("FAIL single_active byte=%h got=%h exp=%h", b, obs_act[63:0], exp_act[63:0]);
            end
            $display("single: byte=%h line=%h", b, obs_line[63:0]);
        end
    endtask

    task automatic test_back_to_back();
        model_q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        build_model(CPB_A);
        clear_obs();
        @(negedge clk);
        drive(0, 1'b1, 8'h01);
        for (int i = 1; i < 6; i++) begin
            @(negedge clk);
            record(0);
            if (i == 4) begin
                checks++;
                if (ready_a !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_ready_before_full got=%b exp=1", ready_a);
                end
            end
            if (i == 5) begin
                checks++;
                if (ready_a !== 1'b0 || ovf_a !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_full ready=%b ovf=%b exp 0 0", ready_a, ovf_a);
                end
            end
            drive(0, 1'b1, 8'(i + 1));
        end
        @(negedge clk);
        record(0);
        checks++;
        if (ovf_a !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ovf_pulse got=%b exp=1", ovf_a);
        end
        drive(0, 1'b0, 8'h00);
        @(negedge clk);
        record(0);
        checks++;
        if (ovf_a !== 1'b0) begin
            failures++;
            $display("FAIL b2b_ovf_clear got=%b exp=0", ovf_a);
        end
        sample_n(0, exp_len - 7);
        checks++;
        if (obs_line !== exp_line) begin
            failures++;
            $display("FAIL b2b_line got=%h exp=%h", obs_line[255:0], exp_line[255:0]);
        end
        checks++;
        if (obs_done !== exp_done || obs_act !== exp_act) begin
            failures++;
            $display("FAIL b2b_done_active done=%h exp=%h act=%h exp=%h",
                     obs_done[255:0], exp_done[255:0], obs_act[255:0], exp_act[255:0]);
        end
        $display("back_to_back: 6 writes, frames=%0d", $countones(obs_done));
    endtask

    task automatic test_random_queue();
        int n;
        for (int it = 0; it < 6; it++) begin
            n = $urandom_range(1, 4);
            model_q.delete();
            for (int i = 0; i < n; i++) model_q.push_back(8'($urandom));
            build_model(CPB_A);
            send_burst(0);
            checks++;
            if (obs_line !== exp_line || obs_act !== exp_act || obs_done !== exp_done) begin
                failures++;
                $display("FAIL random_queue n=%0d line=%h exp=%h", n, obs_line[191:0], exp_line[191:0]);
            end
            $display("random_queue: n=%0d first=%h", n, model_q[0]);
        end
    endtask

    task automatic test_cpb1();
        model_q = {8'h00, 8'hFF};
        build_model(CPB_B);
        send_burst(1);
        checks++;
        if (obs_line !== exp_line) begin
            failures++;
            $display("FAIL cpb1_line got=%h exp=%h", obs_line[63:0], exp_line[63:0]);
        end
        checks++;
        if (obs_act !== exp_act || obs_done !== exp_done) begin
            failures++;
            $display("FAIL cpb1_act_done act=%h exp=%h done=%h exp=%h",
                     obs_act[63:0], exp_act[63:0], obs_done[63:0], exp_done[63:0]);
        end
        for (int it = 0; it < 4; it++) begin
            model_q = {8'($urandom), 8'($urandom), 8'($urandom)};
            build_model(CPB_B);
            send_burst(1);
            checks++;
            if (obs_line !== exp_line || obs_done !== exp_done) begin
                failures++;
                $display("FAIL cpb1_random line=%h exp=%h", obs_line[63:0], exp_line[63:0]);
            end
        end
        $display("cpb1: line=%h", obs_line[63:0]);
    endtask

    task automatic test_reset_midframe();
        int lows = 0;
        int dones = 0;
        clear_obs();
        @(negedge clk);
        drive(0, 1'b1, 8'h3C);
        @(negedge clk);
        record(0);
        drive(0, 1'b1, 8'h11);
        @(negedge clk);
        record(0);
        drive(0, 1'b1, 8'h22);
        @(negedge clk);
        record(0);
        drive(0, 1'b0, 8'h00);
        sample_n(0, 16);
        checks++;
        if (active_a !== 1'b1 || ready_a !== 1'b1) begin
            failures++;
            $display("FAIL midframe_pre active=%b ready=%b exp 1 1", active_a, ready_a);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({serial_a, active_a, done_a, ready_a} !== 4'b1001) begin
            failures++;
            $display("FAIL midframe_async got=%b exp=1001", {serial_a, active_a, done_a, ready_a});
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (serial_a !== 1'b1) lows++;
            if (done_a !== 1'b0) dones++;
        end
        checks++;
        if (lows != 0 || dones != 0 || ready_a !== 1'b1) begin
            failures++;
            $display("FAIL midframe_after lows=%0d dones=%0d ready=%b exp 0 0 1", lows, dones, ready_a);
        end
        $display("reset_midframe: lows=%0d dones=%0d", lows, dones);
    endtask

`ifdef MBO_UART_TX_PARITY_EN
    task automatic test_parity();
        logic [7:0] vals [2];
        logic       pexp [2];
        vals[0] = 8'h07; pexp[0] = 1'b1;
        vals[1] = 8'h03; pexp[1] = 1'b0;
        for (int it = 0; it < 2; it++) begin
            model_q = {vals[it]};
            build_model(CPB_A);
            send_burst(0);
            checks++;
            if (obs_line[1 + 9 * CPB_A] !== pexp[it] || obs_line !== exp_line) begin
                failures++;
                $display("FAIL parity byte=%h got=%h exp=%h", vals[it], obs_line[63:0], exp_line[63:0]);
            end
            checks++;
            if ($countones(obs_act) != 11 * CPB_A) begin
                failures++;
                $display("FAIL parity_len got=%0d exp=%0d", $countones(obs_act), 11 * CPB_A);
            end
            $display("parity: byte=%h bit=%b", vals[it], obs_line[1 + 9 * CPB_A]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        repeat (3) @(negedge clk);
        test_random_queue();
        test_cpb1();
        test_reset_midframe();
`ifdef MBO_UART_TX_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mbo_uart_tx.md
Name: mbo_uart_tx

Overview:
- UART transmitter, 8N1, LSB first; matches the MBO UART receiver on the same link.
- A small input FIFO lets the control logic queue several bytes without waiting on line timing.
- Sits between the command/response logic and the FPGA TX pin; o_Tx_Serial goes directly to an output pad.

Parameters:
- CLKS_PER_BIT, 1, i_Clock cycles per serial bit (1..65535).
- FIFO_DEPTH, 4, byte slots in the input FIFO (power of two, 2..16).

Ports:
- i_Clock  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- i_Tx_DV  in  1  write strobe; the byte is accepted on a rising edge when i_Tx_DV=1 and o_Tx_Ready=1.
- i_Tx_Byte  in  8  byte to send.
- o_Tx_Ready  out  1  FIFO not full.
- o_Tx_Serial  out  1  serial line; registered; idle high; IOB-packed flop.
- o_Tx_Active  out  1  high from the start bit through the end of the stop bit.
- o_Tx_Done  out  1  one-cycle pulse in CLEANUP after each frame.
- o_Tx_Ovf  out  1  one-cycle pulse when i_Tx_DV=1 while o_Tx_Ready=0.

Behaviour:
- Reset (async, any state, including mid-frame):
  - o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Tx_Ovf=0, o_Tx_Ready=1.
  - FIFO emptied, state=IDLE, bit counter=0, clock counter=0.
  - A partial frame is abandoned; the line goes high immediately.
- FIFO:
  - Read/write pointers with wrap-around; count ranges 0..FIFO_DEPTH.
  - o_Tx_Ready = (count != FIFO_DEPTH), decoded from the registered count.
  - Write when not ready: byte dropped, FIFO unchanged, o_Tx_Ovf=1 next cycle.
  - Simultaneous write and pop: count unchanged, both take effect.
  - Full with a simultaneous pop: the write is still rejected, since ready was 0 that cycle.
- Clock counter is 16 bits. Each bit period is exactly CLKS_PER_BIT cycles: count 0..CLKS_PER_BIT-1, then advance.
- State machine:
  - IDLE: o_Tx_Serial=1, o_Tx_Active=0. If FIFO not empty:
    - pop the head into the shift register;
    - o_Tx_Serial<=0, o_Tx_Active<=1, counter<=0;
    - go to START.
  - START: hold 0 for CLKS_PER_BIT cycles, then drive bit0, bit index<=0, go to DATA.
  - DATA: each bit held CLKS_PER_BIT cycles.
    - After bit index 7, drive 1 and go to STOP.
    - Otherwise index+1 and drive the next bit.
  - STOP: hold 1 for CLKS_PER_BIT cycles, then o_Tx_Active<=0, o_Tx_Done<=1, go to CLEANUP.
  - CLEANUP: one cycle, o_Tx_Done<=0, go to IDLE.
  - Undefined state codes: go to IDLE with line high.
- Latency: byte written at edge k into an empty FIFO with the block in IDLE → o_Tx_Serial falls after edge k+1.
- Frame length: 10*CLKS_PER_BIT cycles low-to-end-of-stop.
- Back-to-back frames: 2 extra high cycles (CLEANUP + IDLE pop) between the stop bit and the next start bit.
- CLKS_PER_BIT=1: every bit lasts one cycle; rules unchanged.
- i_Tx_Byte is captured only at the FIFO write; later changes do not affect queued or in-flight bytes.

Optional Feature:
- Macro MBO_UART_TX_PARITY_EN.
- Defined: state PARITY is inserted between DATA and STOP.
  - Drives even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - Frame = 11*CLKS_PER_BIT cycles.
- Undefined: no PARITY state; 8N1 frame as above; no parity logic synthesised.

Test Plan:
- CLKS_PER_BIT=4, write 0xA5 once → after edge k+1:
  - line 0 for 4 cycles;
  - then 1,0,1,0,0,1,0,1 at 4 cycles each;
  - then 1 for 4 cycles;
  - o_Tx_Done pulses once; o_Tx_Active high exactly 40 cycles.
- CLKS_PER_BIT=4, FIFO_DEPTH=4:
  - write 0x01,0x02,0x03,0x04,0x05,0x06 on consecutive cycles → first pop frees one slot, so 5 bytes are accepted;
  - 6th write gives o_Tx_Ready=0 and an o_Tx_Ovf pulse;
  - 5 frames in order, separated by 2 idle-high cycles.
- CLKS_PER_BIT=1, write 0x00 then 0xFF back-to-back → frames 0000000001 and 0111111111 with a 2-cycle high gap.
- Assert rst during bit 3 of 0x3C with 2 bytes queued → o_Tx_Serial=1 immediately, FIFO empty, no o_Tx_Done, o_Tx_Ready=1.
- Loopback to the MBO UART receiver, CLKS_PER_BIT=87, 256 bytes 0x00..0xFF → every byte received intact, in order.
- With MBO_UART_TX_PARITY_EN, write 0x07 → parity bit=1 after bit7; 0x03 → parity bit=0; frame 11*CLKS_PER_BIT cycles.
